// File: rtl/rx_ctrl_pkg.sv
// Shared types and sizes for the RX FIFO burst controller.
package rx_ctrl_pkg;

  localparam int unsigned BYTES_PER_WORD = 16;
  localparam int unsigned RD_WORD_W      = 128;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned AVAIL_W        = 9;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    XFER      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rx_ctrl_skid.sv
// Two-entry valid/ready buffer for FIFO read words; head entry drives the output
// directly from flops. occ_c is the occupancy left after this cycle's pop, so the
// read-issue logic can keep one word per cycle flowing.
module rx_ctrl_skid
  import rx_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 tb_rst,
  input  logic                 in_valid,
  input  logic [RD_WORD_W-1:0] in_data,
  output logic                 out_valid,
  output logic [RD_WORD_W-1:0] out_data,
  input  logic                 out_ready,
  output logic [1:0]           occ_c
);

  logic                 head_v;
  logic                 tail_v;
  logic [RD_WORD_W-1:0] head_d;
  logic [RD_WORD_W-1:0] tail_d;
  logic                 pop;

  assign pop       = head_v & out_ready;
  assign out_valid = head_v;
  assign out_data  = head_d;
  assign occ_c     = 2'(head_v) + 2'(tail_v) - 2'(pop);

  // Head/tail storage: pop promotes tail to head, push fills the first free slot.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      head_v <= 1'b0;
      tail_v <= 1'b0;
      head_d <= '0;
      tail_d <= '0;
    end else if (pop) begin
      if (tail_v) begin
        head_d <= tail_d;
        tail_v <= in_valid;
        if (in_valid) tail_d <= in_data;
      end else begin
        head_v <= in_valid;
        if (in_valid) head_d <= in_data;
      end
    end else if (in_valid) begin
      if (!head_v) begin
        head_v <= 1'b1;
        head_d <= in_data;
      end else begin
        tail_v <= 1'b1;
        tail_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/rx_fifo_burst_ctrl.sv
// Capture-path sequencer for RX_FIFO: gates bytes in, counts readable 128-bit words,
// requests the frame-buffer arbiter per burst and drains the burst with valid/ready
// while walking a wrapping frame address.
// Optional feature macro: RX_CTRL_DROP_CNT_EN adds a saturating drop_cnt[15:0] output.
module rx_fifo_burst_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 115200
) (
  input  logic                 clk,
  input  logic                 tb_rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           fifo_wr_data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_wr_full,
  output logic                 fifo_rd_en,
  input  logic [RD_WORD_W-1:0] fifo_rd_data,
  input  logic                 fifo_rd_empty,
  input  logic                 frame_start,
  output logic                 wr_req,
  input  logic                 wr_gnt,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_len,
  output logic [RD_WORD_W-1:0] wr_data,
  output logic                 wr_data_valid,
  input  logic                 wr_data_ready,
  input  logic                 wr_done,
  output logic                 busy,
  output logic                 overflow
`ifdef RX_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int unsigned AW1 = ADDR_W + 1;

  state_t                state_q;
  state_t                state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [AVAIL_W-1:0]    avail;
  logic [CNT_W-1:0]      rd_issued;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  rd_inflight;
  logic                  frame_pend;
  logic [1:0]            skid_occ_c;
  logic                  word_done;
  logic                  beat_fire;
  logic                  drop;
  logic [AW1-1:0]        addr_sum;
  logic [AW1-1:0]        addr_limit;

  // Write side is a pure gate onto the FIFO.
  assign fifo_wr_en   = in_valid & ~fifo_wr_full;
  assign fifo_wr_data = in_data;
  assign drop         = in_valid & fifo_wr_full;
  assign word_done    = fifo_wr_en & (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign beat_fire    = wr_data_valid & wr_data_ready;
  assign wr_len       = 8'(BURST_LEN);
  assign addr_sum     = AW1'(wr_addr) + AW1'(BURST_LEN);
  assign addr_limit   = AW1'(BASE_ADDR + FRAME_WORDS);

  // Byte and readable-word accounting, sticky overflow.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      byte_cnt    <= '0;
      avail       <= '0;
      overflow    <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      if (fifo_wr_en) byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      avail       <= avail + AVAIL_W'(word_done) - AVAIL_W'(fifo_rd_en);
      overflow    <= overflow | drop;
      rd_inflight <= fifo_rd_en;
    end
  end

`ifdef RX_CTRL_DROP_CNT_EN
  // Saturating count of bytes dropped against a full FIFO.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (avail >= AVAIL_W'(BURST_LEN)) state_d = REQ;
      REQ:       if (wr_gnt) state_d = XFER;
      XFER:      if (beat_fire && (beat_cnt == CNT_W'(BURST_LEN - 1))) state_d = WAIT_DONE;
      WAIT_DONE: if (wr_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs; reads are throttled so skid plus in-flight never exceeds two words.
  always_comb begin
    wr_req     = 1'b0;
    busy       = 1'b0;
    fifo_rd_en = 1'b0;
    wr_req     = (state_q == REQ);
    busy       = (state_q != IDLE);
    fifo_rd_en = (state_q == XFER) && (rd_issued < CNT_W'(BURST_LEN)) &&
                 ((3'(skid_occ_c) + 3'(rd_inflight)) < 3'd2) &&
                 !fifo_rd_empty && (avail != '0);
  end

  // Per-burst read and beat counters, cleared outside XFER.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_issued <= '0;
      beat_cnt  <= '0;
    end else if (state_q != XFER) begin
      rd_issued <= '0;
      beat_cnt  <= '0;
    end else begin
      if (fifo_rd_en) rd_issued <= rd_issued + CNT_W'(1);
      if (beat_fire)  beat_cnt  <= beat_cnt + CNT_W'(1);
    end
  end

  // Frame address walk; a frame_start outside IDLE is held until the burst completes.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_addr    <= ADDR_W'(BASE_ADDR);
      frame_pend <= 1'b0;
    end else if (state_q == IDLE) begin
      if (frame_start) begin
        wr_addr    <= ADDR_W'(BASE_ADDR);
        frame_pend <= 1'b0;
      end
    end else begin
      if (frame_start) frame_pend <= 1'b1;
      if ((state_q == WAIT_DONE) && wr_done) begin
        frame_pend <= 1'b0;
        if (frame_pend || frame_start) wr_addr <= ADDR_W'(BASE_ADDR);
        else if (addr_sum >= addr_limit) wr_addr <= ADDR_W'(BASE_ADDR);
        else wr_addr <= addr_sum[ADDR_W-1:0];
      end
    end
  end

  rx_ctrl_skid u_skid (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .in_valid  (rd_inflight),
    .in_data   (fifo_rd_data),
    .out_valid (wr_data_valid),
    .out_data  (wr_data),
    .out_ready (wr_data_ready),
    .occ_c     (skid_occ_c)
  );

endmodule

// File: tb/tb_rx_fifo_burst_ctrl.sv
// Directed bench for rx_fifo_burst_ctrl with a byte-in/word-out FIFO model
// (first byte lands in the least significant byte of the word).
module tb_rx_fifo_burst_ctrl;

  logic         clk;
  logic         tb_rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic [7:0]   fifo_wr_data;
  logic         fifo_wr_en;
  logic         fifo_wr_full;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data;
  logic         fifo_rd_empty;
  logic         frame_start;
  logic         wr_req;
  logic         wr_gnt;
  logic [27:0]  wr_addr;
  logic [7:0]   wr_len;
  logic [127:0] wr_data;
  logic         wr_data_valid;
  logic         wr_data_ready;
  logic         wr_done;
  logic         busy;
  logic         overflow;
`ifdef RX_CTRL_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int vectors;
  int miscompares;
  int byte_n;
  int exp_w;

  rx_fifo_burst_ctrl #(
    .BURST_LEN   (16),
    .ADDR_W      (28),
    .BASE_ADDR   (0),
    .FRAME_WORDS (32)
  ) dut (
    .clk           (clk),
    .tb_rst        (tb_rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_full  (fifo_wr_full),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .frame_start   (frame_start),
    .wr_req        (wr_req),
    .wr_gnt        (wr_gnt),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_done       (wr_done),
    .busy          (busy),
    .overflow      (overflow)
`ifdef RX_CTRL_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: 8-bit writes, 128-bit reads, data valid the cycle after rd_en.
  logic [7:0] fq[$];
  int         fcount;

  function automatic logic [127:0] head_word();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = fq[i];
    return w;
  endfunction

  assign fifo_rd_empty = (fcount < 16);

  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      fq.delete();
      fcount       <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fcount >= 16) begin
        fifo_rd_data <= head_word();
        for (int i = 0; i < 16; i++) void'(fq.pop_front());
      end
      if (fifo_wr_en) fq.push_back(fifo_wr_data);
      fcount <= fcount + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fcount >= 16) ? 16 : 0);
    end
  end

  // Bus monitor: counts reads, collects accepted beats, tracks outstanding words.
  int           rd_cnt;
  int           viol;
  int           underrun;
  int           outst;
  logic [127:0] beats[$];

  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      outst <= 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (outst - ((wr_data_valid && wr_data_ready) ? 1 : 0) >= 2) viol <= viol + 1;
        if (fcount < 16) underrun <= underrun + 1;
      end
      if (wr_data_valid && wr_data_ready) beats.push_back(wr_data);
      outst <= outst + (fifo_rd_en ? 1 : 0) - ((wr_data_valid && wr_data_ready) ? 1 : 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] exp_word(input int w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(255 - ((16 * w + i) % 256));
    return r;
  endfunction

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = 8'(255 - (byte_n % 256));
      in_valid = 1'b1;
      byte_n++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input int bound);
    int lat;
    lat = 0;
    while (!wr_req && lat < bound) begin
      tick();
      lat++;
    end
  endtask

  // One full burst: grant, drain 16 beats under the chosen ready pattern, complete.
  task automatic run_burst(input logic [27:0] exp_addr, input int mode, input bit fs_mid);
    int lat;
    int k;
    int b0;
    int r0;
    logic [127:0] got;
    wait_req(40);
    chk("req_seen", wr_req, 1);
    chk("burst_addr", wr_addr, exp_addr);
    b0 = beats.size();
    r0 = rd_cnt;
    wr_data_ready = (mode == 0);
    wr_gnt = 1'b1;
    tick();
    wr_gnt = 1'b0;
    chk("req_drop", wr_req, 0);
    lat = 0;
    while (!wr_data_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("gnt_to_valid", lat, 2);
    k = 0;
    while ((beats.size() - b0) < 16 && k < 200) begin
      wr_data_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      frame_start   = fs_mid && (k == 4);
      tick();
      k++;
    end
    wr_data_ready = 1'b0;
    frame_start   = 1'b0;
    chk("beat_count", beats.size() - b0, 16);
    chk("rd_en_count", rd_cnt - r0, 16);
    for (int j = 0; j < 16; j++) begin
      got = (b0 + j < beats.size()) ? beats[b0 + j] : 'x;
      chk("beat_data", got, exp_word(exp_w + j));
    end
    exp_w += 16;
    tick();
    chk("wait_done_busy", busy, 1);
    chk("no_extra_valid", wr_data_valid, 0);
    chk("addr_stable", wr_addr, exp_addr);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int k;
    int b0;
    logic [127:0] lit;
    tb_rst        = 1'b1;
    in_data       = '0;
    in_valid      = 1'b0;
    fifo_wr_full  = 1'b0;
    frame_start   = 1'b0;
    wr_gnt        = 1'b0;
    wr_data_ready = 1'b0;
    wr_done       = 1'b0;
    byte_n        = 0;
    exp_w         = 0;

    // Reset held 200 ns.
    repeat (20) tick();
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_valid", wr_data_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_len", wr_len, 16);
`ifdef RX_CTRL_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    tb_rst = 1'b0;
    tick();

    // Burst at 0, full-rate drain.
    send_bytes(256);
    wait_req(2);
    chk("req_within_2", wr_req, 1);
    run_burst(28'd0, 0, 1'b0);
    lit = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    chk("first_word_literal", beats[0], lit);
    chk("addr_after_b1", wr_addr, 16);

    // Burst at 16 under 1,0,0 backpressure; frame of 32 words wraps to 0.
    send_bytes(256);
    run_burst(28'd16, 1, 1'b0);
    chk("addr_wrap", wr_addr, 0);
    chk("rd_occ_limit", viol, 0);

    // frame_start during XFER of burst at 0 overrides the +16 step.
    send_bytes(256);
    run_burst(28'd0, 0, 1'b1);
    chk("addr_frame_restart", wr_addr, 0);

    // Next burst steps normally again.
    send_bytes(256);
    run_burst(28'd0, 1, 1'b0);
    chk("addr_after_b4", wr_addr, 16);

    // frame_start in IDLE resets the address the next cycle.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("idle_frame_start", wr_addr, 0);
    chk("rd_occ_limit2", viol, 0);
    chk("no_underrun", underrun, 0);

    // Overflow: 10 bytes against a full FIFO.
    chk("overflow_pre", overflow, 0);
    fifo_wr_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data  = 8'hA5;
      in_valid = 1'b1;
      #1;
      chk("wr_en_blocked", fifo_wr_en, 0);
      tick();
    end
    in_valid     = 1'b0;
    fifo_wr_full = 1'b0;
    chk("overflow_set", overflow, 1);
`ifdef RX_CTRL_DROP_CNT_EN
    chk("drop_cnt_10", drop_cnt, 10);
`endif
    tick();
    chk("overflow_sticky", overflow, 1);
    chk("no_req_after_drop", wr_req, 0);

    // Reset in the middle of a transfer after 5 beats.
    send_bytes(256);
    wait_req(40);
    chk("req_before_abort", wr_req, 1);
    wr_data_ready = 1'b1;
    wr_gnt = 1'b1;
    tick();
    wr_gnt = 1'b0;
    b0 = beats.size();
    k = 0;
    while ((beats.size() - b0) < 5 && k < 50) begin
      tick();
      k++;
    end
    chk("beats_before_rst", beats.size() - b0, 5);
    tb_rst = 1'b1;
    #1;
    chk("abort_valid", wr_data_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", fifo_rd_en, 0);
    repeat (3) tick();
    tb_rst        = 1'b0;
    wr_data_ready = 1'b0;
    tick();
    chk("abort_overflow_clr", overflow, 0);
    chk("abort_addr", wr_addr, 0);
`ifdef RX_CTRL_DROP_CNT_EN
    chk("abort_drop_cnt", drop_cnt, 0);
`endif
    byte_n = 0;
    exp_w  = 0;
    send_bytes(240);
    repeat (5) tick();
    chk("no_req_15_words", wr_req, 0);
    send_bytes(16);
    wait_req(2);
    chk("req_after_16_words", wr_req, 1);
    run_burst(28'd0, 0, 1'b0);
    chk("addr_after_abort_burst", wr_addr, 16);
    chk("rd_occ_limit3", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
